// File: rtl/dmi_ctrl_pkg.sv
// rtl/dmi_ctrl_pkg.sv - DMI op/status codes, default address width and controller state encodings
package dmi_ctrl_pkg;

    localparam int DMI_ABITS = 7;

    localparam logic [1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;

    localparam logic [1:0] DMI_STAT_OK     = 2'd0;
    localparam logic [1:0] DMI_STAT_FAILED = 2'd2;
    localparam logic [1:0] DMI_STAT_BUSY   = 2'd3;

    typedef enum logic [1:0] {
        DMI_ST_IDLE = 2'd0,
        DMI_ST_REQ  = 2'd1,
        DMI_ST_RESP = 2'd2
    } dmi_state_e;

endpackage

// File: rtl/dmi_ctrl.sv
// rtl/dmi_ctrl.sv - DTM-side DMI transaction controller, one outstanding DM request, sticky dmistat
// Optional request/response timeout enabled by defining DMI_TIMEOUT_EN.
module dmi_ctrl
    import dmi_ctrl_pkg::*;
#(
    parameter int ABITS          = DMI_ABITS,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               sys_clk,
    input  logic               sys_rstn,
    input  logic               dmi_update,
    input  logic [ABITS-1:0]   dmi_wr_addr,
    input  logic [31:0]        dmi_wr_data,
    input  logic [1:0]         dmi_wr_op,
    input  logic               dmi_capture,
    output logic [ABITS+33:0]  dmi_rd_bits,
    input  logic               dmireset,
    input  logic               dmihardreset,
    output logic [1:0]         dmistat,
    output logic               dtm_req_valid,
    input  logic               dtm_req_ready,
    output logic [ABITS+33:0]  dtm_req_bits,
    input  logic               dm_resp_valid,
    output logic               dm_resp_ready,
    input  logic [33:0]        dm_resp_bits
);

    dmi_state_e         state_q, state_d;
    logic [ABITS-1:0]   req_addr_q, req_addr_d;
    logic [31:0]        req_data_q, req_data_d;
    logic [1:0]         req_op_q, req_op_d;
    logic [31:0]        last_data_q, last_data_d;
    logic [1:0]         dmistat_q, dmistat_d;
    logic [ABITS+33:0]  rd_bits_q, rd_bits_d;
    logic               busy;
    logic               resp_taken;

`ifdef DMI_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        req_op_d    = req_op_q;
        last_data_d = last_data_q;
        dmistat_d   = dmistat_q;
        rd_bits_d   = rd_bits_q;
        busy        = (state_q != DMI_ST_IDLE);
        resp_taken  = 1'b0;
`ifdef DMI_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif

        if (dmi_capture) begin
            rd_bits_d = {req_addr_q, last_data_q, busy ? DMI_STAT_BUSY : dmistat_q};
        end

        case (state_q)
            DMI_ST_IDLE: begin
                if (dmi_update && !dmireset && !dmihardreset && dmistat_q == DMI_STAT_OK &&
                    (dmi_wr_op == DMI_OP_READ || dmi_wr_op == DMI_OP_WRITE)) begin
                    req_addr_d = dmi_wr_addr;
                    req_data_d = dmi_wr_data;
                    req_op_d   = dmi_wr_op;
                    // A write reports its own scanned data on the next capture
                    if (dmi_wr_op == DMI_OP_WRITE) begin
                        last_data_d = dmi_wr_data;
                    end
                    state_d = DMI_ST_REQ;
`ifdef DMI_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            DMI_ST_REQ: begin
                if (dtm_req_ready) begin
                    state_d = DMI_ST_RESP;
                end
            end
            DMI_ST_RESP: begin
                if (dm_resp_valid) begin
                    resp_taken = 1'b1;
                    if (req_op_q == DMI_OP_READ) begin
                        last_data_d = dm_resp_bits[33:2];
                    end
                    if (dm_resp_bits[1:0] != 2'd0 && dmistat_q == DMI_STAT_OK) begin
                        dmistat_d = DMI_STAT_FAILED;
                    end
                    state_d = DMI_ST_IDLE;
                end
            end
            default: state_d = DMI_ST_IDLE;
        endcase

        if (busy && (dmi_update || dmi_capture) && dmistat_q == DMI_STAT_OK) begin
            dmistat_d = DMI_STAT_BUSY;
        end

`ifdef DMI_TIMEOUT_EN
        if (busy) begin
            cnt_d = cnt_q + 1'b1;
            // A response landing in the expiry cycle completes normally
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1) && !resp_taken) begin
                state_d = DMI_ST_IDLE;
                if (dmistat_q == DMI_STAT_OK) begin
                    dmistat_d = DMI_STAT_FAILED;
                end
            end
        end
`endif

        if (dmireset) begin
            dmistat_d = DMI_STAT_OK;
        end
        if (dmihardreset) begin
            state_d   = DMI_ST_IDLE;
            dmistat_d = DMI_STAT_OK;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q     <= DMI_ST_IDLE;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_op_q    <= '0;
            last_data_q <= '0;
            dmistat_q   <= DMI_STAT_OK;
            rd_bits_q   <= '0;
`ifdef DMI_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            req_op_q    <= req_op_d;
            last_data_q <= last_data_d;
            dmistat_q   <= dmistat_d;
            rd_bits_q   <= rd_bits_d;
`ifdef DMI_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign dtm_req_valid = (state_q == DMI_ST_REQ);
    assign dm_resp_ready = (state_q == DMI_ST_RESP);
    assign dtm_req_bits  = {req_addr_q, req_data_q, req_op_q};
    assign dmistat       = dmistat_q;
    assign dmi_rd_bits   = rd_bits_q;

endmodule

// File: tb/tb_dmi_ctrl.sv
// tb/tb_dmi_ctrl.sv - scoreboard bench for dmi_ctrl; request beats checked against a queue of expected bits
module tb_dmi_ctrl;

    localparam int AB = 7;
    localparam int MW = AB + 34;

    logic            sys_clk = 1'b0;
    logic            sys_rstn = 1'b0;
    logic            dmi_update = 1'b0;
    logic [AB-1:0]   dmi_wr_addr = '0;
    logic [31:0]     dmi_wr_data = '0;
    logic [1:0]      dmi_wr_op = '0;
    logic            dmi_capture = 1'b0;
    logic [MW-1:0]   dmi_rd_bits;
    logic            dmireset = 1'b0;
    logic            dmihardreset = 1'b0;
    logic [1:0]      dmistat;
    logic            dtm_req_valid;
    logic            dtm_req_ready = 1'b0;
    logic [MW-1:0]   dtm_req_bits;
    logic            dm_resp_valid = 1'b0;
    logic            dm_resp_ready;
    logic [33:0]     dm_resp_bits = '0;

    int tests = 0;
    int fails = 0;
    int hs_count = 0;
    logic [MW-1:0] exp_q[$];

    dmi_ctrl #(.ABITS(AB), .TIMEOUT_CYCLES(16)) dut (
        .sys_clk(sys_clk), .sys_rstn(sys_rstn),
        .dmi_update(dmi_update), .dmi_wr_addr(dmi_wr_addr), .dmi_wr_data(dmi_wr_data),
        .dmi_wr_op(dmi_wr_op), .dmi_capture(dmi_capture), .dmi_rd_bits(dmi_rd_bits),
        .dmireset(dmireset), .dmihardreset(dmihardreset), .dmistat(dmistat),
        .dtm_req_valid(dtm_req_valid), .dtm_req_ready(dtm_req_ready), .dtm_req_bits(dtm_req_bits),
        .dm_resp_valid(dm_resp_valid), .dm_resp_ready(dm_resp_ready), .dm_resp_bits(dm_resp_bits)
    );

    always #5 sys_clk = ~sys_clk;

    // Request monitor: every accepted beat must match the oldest expected request
    always @(negedge sys_clk) begin
        if (sys_rstn && dtm_req_valid && dtm_req_ready) begin
            logic [MW-1:0] e;
            hs_count++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL req_beat unexpected: got %h, expected none", dtm_req_bits);
            end else begin
                e = exp_q.pop_front();
                if (dtm_req_bits !== e) begin
                    fails++;
                    $display("FAIL req_beat: got %h, expected %h", dtm_req_bits, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_update(input logic [AB-1:0] a, input logic [31:0] d, input logic [1:0] op,
                             input bit expect_req);
        dmi_update = 1'b1; dmi_wr_addr = a; dmi_wr_data = d; dmi_wr_op = op;
        if (expect_req) exp_q.push_back({a, d, op});
        tick();
        dmi_update = 1'b0;
    endtask

    task automatic respond(input int delay, input logic [31:0] d, input logic [1:0] r);
        int n = 0;
        while (dm_resp_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        tests++;
        if (dm_resp_ready !== 1'b1) begin
            fails++;
            $display("FAIL resp_wait: dm_resp_ready %b, expected 1 within 50 cycles", dm_resp_ready);
        end
        repeat (delay) tick();
        dm_resp_valid = 1'b1; dm_resp_bits = {d, r};
        tick();
        dm_resp_valid = 1'b0; dm_resp_bits = '0;
    endtask

    task automatic capture_check(input string name, input logic [MW-1:0] e);
        dmi_capture = 1'b1;
        tick();
        dmi_capture = 1'b0;
        tests++;
        if (dmi_rd_bits !== e) begin
            fails++;
            $display("FAIL %s: dmi_rd_bits %h, expected %h", name, dmi_rd_bits, e);
        end
    endtask

    task automatic check_stat(input string name, input logic [1:0] e);
        tests++;
        if (dmistat !== e) begin
            fails++;
            $display("FAIL %s: dmistat %0d, expected %0d", name, dmistat, e);
        end
    endtask

    task automatic check_idle(input string name);
        tests++;
        if (dtm_req_valid !== 1'b0 || dm_resp_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s: valid %b ready %b, expected 0 0", name, dtm_req_valid, dm_resp_ready);
        end
    endtask

    task automatic test_reset();
        sys_rstn = 1'b0;
        repeat (3) tick();
        check_idle("reset_handshake");
        check_stat("reset_dmistat", 2'd0);
        tests++;
        if (dmi_rd_bits !== '0 || dtm_req_bits !== '0) begin
            fails++;
            $display("FAIL reset_bits: rd %h req %h, expected 0 0", dmi_rd_bits, dtm_req_bits);
        end
        sys_rstn = 1'b1;
        tick();
    endtask

    task automatic test_write();
        int h0 = hs_count;
        dtm_req_ready = 1'b1;
        do_update(7'h04, 32'hDEADBEEF, 2'd2, 1'b1);
        respond(3, 32'h0, 2'd0);
        check_idle("write_done");
        check_stat("write_stat", 2'd0);
        tests++;
        if (hs_count - h0 !== 1) begin
            fails++;
            $display("FAIL write_beats: %0d beats, expected 1", hs_count - h0);
        end
        capture_check("write_capture", {7'h04, 32'hDEADBEEF, 2'd0});
    endtask

    task automatic test_read();
        dtm_req_ready = 1'b1;
        do_update(7'h11, 32'h12345678, 2'd1, 1'b1);
        respond(1, 32'h00030382, 2'd0);
        capture_check("read_capture", {7'h11, 32'h00030382, 2'd0});
    endtask

    task automatic test_busy();
        int h0;
        dtm_req_ready = 1'b0;
        do_update(7'h20, 32'h0, 2'd1, 1'b1);
        do_update(7'h17, 32'h99, 2'd2, 1'b0);
        check_stat("busy_stat", 2'd3);
        tests++;
        if (dtm_req_valid !== 1'b1 || dtm_req_bits !== {7'h20, 32'h0, 2'd1}) begin
            fails++;
            $display("FAIL busy_hold: valid %b bits %h, expected 1 %h", dtm_req_valid, dtm_req_bits,
                     {7'h20, 32'h0, 2'd1});
        end
        capture_check("busy_capture", {7'h20, 32'h00030382, 2'd3});
        dtm_req_ready = 1'b1;
        respond(0, 32'hCAFEF00D, 2'd0);
        h0 = hs_count;
        do_update(7'h30, 32'h1, 2'd2, 1'b0);
        repeat (4) tick();
        tests++;
        if (hs_count !== h0) begin
            fails++;
            $display("FAIL busy_ignore: %0d beats, expected 0", hs_count - h0);
        end
        check_stat("busy_sticky", 2'd3);
        dmireset = 1'b1; tick(); dmireset = 1'b0;
        check_stat("busy_cleared", 2'd0);
        capture_check("busy_after", {7'h20, 32'hCAFEF00D, 2'd0});
    endtask

    task automatic test_failed();
        int h0;
        dtm_req_ready = 1'b1;
        do_update(7'h3C, 32'h55AA55AA, 2'd2, 1'b1);
        respond(2, 32'h0, 2'd2);
        check_stat("failed_stat", 2'd2);
        h0 = hs_count;
        do_update(7'h01, 32'h0, 2'd1, 1'b0);
        repeat (3) tick();
        dmireset = 1'b1;
        do_update(7'h02, 32'h0, 2'd1, 1'b0);
        dmireset = 1'b0;
        check_stat("failed_reset", 2'd0);
        repeat (3) tick();
        check_idle("failed_dropped_state");
        tests++;
        if (hs_count !== h0) begin
            fails++;
            $display("FAIL failed_dropped: %0d beats, expected 0", hs_count - h0);
        end
        capture_check("failed_capture", {7'h3C, 32'h55AA55AA, 2'd0});
    endtask

    task automatic test_hardreset();
        dtm_req_ready = 1'b0;
        do_update(7'h05, 32'h0, 2'd1, 1'b0);
        tests++;
        if (dtm_req_valid !== 1'b1) begin
            fails++;
            $display("FAIL hard_req: valid %b, expected 1", dtm_req_valid);
        end
        dmi_capture = 1'b1; tick(); dmi_capture = 1'b0;
        dmihardreset = 1'b1; tick(); dmihardreset = 1'b0;
        check_idle("hard_idle");
        check_stat("hard_stat", 2'd0);
        dtm_req_ready = 1'b1;
        do_update(7'h06, 32'h0, 2'd1, 1'b1);
        respond(0, 32'h11112222, 2'd0);
        capture_check("hard_capture", {7'h06, 32'h11112222, 2'd0});
    endtask

    task automatic test_back_to_back();
        dtm_req_ready = 1'b1;
        do_update(7'h41, 32'hA5A5A5A5, 2'd2, 1'b1);
        respond(0, 32'h0, 2'd0);
        do_update(7'h42, 32'h5A5A5A5A, 2'd2, 1'b1);
        respond(0, 32'h0, 2'd0);
        do_update(7'h43, 32'h0, 2'd1, 1'b1);
        respond(0, 32'h76543210, 2'd0);
        check_stat("b2b_stat", 2'd0);
        capture_check("b2b_capture", {7'h43, 32'h76543210, 2'd0});
    endtask

    task automatic test_timeout();
        dtm_req_ready = 1'b1;
        do_update(7'h07, 32'h0, 2'd1, 1'b1);
`ifdef DMI_TIMEOUT_EN
        repeat (15) tick();
        tests++;
        if (dm_resp_ready !== 1'b1) begin
            fails++;
            $display("FAIL timeout_early: dm_resp_ready %b, expected 1", dm_resp_ready);
        end
        tick();
        check_idle("timeout_idle");
        check_stat("timeout_stat", 2'd2);
        dmireset = 1'b1; tick(); dmireset = 1'b0;
`else
        repeat (1000) tick();
        tests++;
        if (dm_resp_ready !== 1'b1) begin
            fails++;
            $display("FAIL no_timeout: dm_resp_ready %b, expected 1", dm_resp_ready);
        end
        dmihardreset = 1'b1; tick(); dmihardreset = 1'b0;
`endif
        check_idle("timeout_cleanup");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_busy();
        test_failed();
        test_hardreset();
        test_back_to_back();
        test_timeout();
        tick();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d requests outstanding, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
